// File: rtl/fft_config_mc.sv
// fft_config_mc
// Builds the configuration word for a multi-channel FFT core and delivers it
// as a single-beat AXI-Stream transfer. Up to one further commit is held in a
// one-deep queue while a transfer is outstanding; a queued word that gets
// replaced or discarded sets the sticky overrun flag.
//
// Ports
//   clk, resetn      clock, synchronous active-low reset
//   nfft             log2 transform size (used only when HAS_NFFT=1)
//   cp_len           cyclic-prefix length (used only when HAS_CP=1)
//   forward          per-channel direction, 1 = forward
//   scale_sch        per-channel scaling schedule, channel k at [k*SCALE_WIDTH +: SCALE_WIDTH]
//   commit           one-cycle request to capture and send the inputs above
//   clear_overrun    clears overrun (a simultaneous new overrun wins)
//   tready           AXIS ready from the FFT core
//   tvalid/tlast     AXIS valid / last (identical, every transfer is one beat)
//   tdata            packed configuration word
//   busy             transfer outstanding (same as tvalid)
//   pending          a queued word is waiting behind the current one
//   overrun          sticky: a queued word was lost
//   sent_count       number of completed handshakes, wraps at 16 bits
module fft_config_mc #(
    parameter int NUM_CHANNELS = 1,
    parameter int SCALE_WIDTH  = 8,
    parameter int HAS_NFFT     = 0,
    parameter int HAS_CP       = 0,
    parameter int CP_WIDTH     = 12,
    localparam int NFFT_F      = (HAS_NFFT != 0) ? 8 : 0,
    localparam int CP_F        = (HAS_CP != 0) ? ((CP_WIDTH + 7) / 8) * 8 : 0,
    localparam int PAYLOAD_W   = NFFT_F + CP_F + NUM_CHANNELS * (1 + SCALE_WIDTH),
    localparam int TDATA_WIDTH = ((PAYLOAD_W + 7) / 8) * 8
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [4:0]                          nfft,
    input  logic [CP_WIDTH-1:0]                 cp_len,
    input  logic [NUM_CHANNELS-1:0]             forward,
    input  logic [NUM_CHANNELS*SCALE_WIDTH-1:0] scale_sch,
    input  logic                                commit,
    input  logic                                clear_overrun,
    input  logic                                tready,
    output logic                                tvalid,
    output logic                                tlast,
    output logic [TDATA_WIDTH-1:0]              tdata,
    output logic                                busy,
    output logic                                pending,
    output logic                                overrun,
    output logic [15:0]                         sent_count
);

    localparam int SCH_W   = NUM_CHANNELS * SCALE_WIDTH;
    localparam int OFF_CP  = NFFT_F;
    localparam int OFF_FWD = NFFT_F + CP_F;
    localparam int OFF_SCH = OFF_FWD + NUM_CHANNELS;
    // Scratch width large enough for every field at its maximum offset, so
    // the shifts below never fall off the top before truncation.
    localparam int WIDE    = 24 + NUM_CHANNELS * (1 + SCALE_WIDTH) + 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state, state_nx;
    logic [TDATA_WIDTH-1:0] shadow, shadow_nx;
    logic [TDATA_WIDTH-1:0] queue_word, queue_nx;
    logic                   pending_nx;
    logic                   overrun_nx;
    logic                   set_ovr;
    logic                   hs;
    logic [TDATA_WIDTH-1:0] packed_word;

    // Fields are laid out LSB first; disabled fields take no bits and the
    // top is zero padded to a byte boundary.
    function automatic logic [TDATA_WIDTH-1:0] pack(
        input logic [4:0]              n,
        input logic [CP_WIDTH-1:0]     cp,
        input logic [NUM_CHANNELS-1:0] f,
        input logic [SCH_W-1:0]        s
    );
        logic [WIDE-1:0] w;
        w = (WIDE'(f) << OFF_FWD) | (WIDE'(s) << OFF_SCH);
        if (HAS_NFFT != 0) w = w | WIDE'(n);
        if (HAS_CP != 0)   w = w | (WIDE'(cp) << OFF_CP);
        return w[TDATA_WIDTH-1:0];
    endfunction

    assign packed_word = pack(nfft, cp_len, forward, scale_sch);
    assign hs          = tvalid & tready;

    always_comb begin
        state_nx   = state;
        shadow_nx  = shadow;
        queue_nx   = queue_word;
        pending_nx = pending;
        set_ovr    = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    shadow_nx = packed_word;
                    state_nx  = SEND;
                end
            end
            SEND: begin
                if (hs && commit) begin
                    // The new commit overtakes any queued word.
                    shadow_nx = packed_word;
                    if (pending) begin
                        pending_nx = 1'b0;
                        set_ovr    = 1'b1;
                    end
                end else if (hs) begin
                    if (pending) begin
                        shadow_nx  = queue_word;
                        pending_nx = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (commit) begin
                    queue_nx   = packed_word;
                    pending_nx = 1'b1;
                    set_ovr    = pending;
                end
            end
            default: state_nx = IDLE;
        endcase
        overrun_nx = set_ovr | (overrun & ~clear_overrun);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            shadow     <= '0;
            queue_word <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            sent_count <= 16'd0;
        end else begin
            state      <= state_nx;
            shadow     <= shadow_nx;
            queue_word <= queue_nx;
            pending    <= pending_nx;
            overrun    <= overrun_nx;
            if (hs) sent_count <= sent_count + 16'd1;
        end
    end

    assign tvalid = (state == SEND);
    assign tlast  = tvalid;
    assign busy   = tvalid;
    assign tdata  = shadow;

endmodule

// File: doc/fft_config_mc.md
# fft_config_mc

Parametrised AXI-Stream configuration-word generator for a multi-channel FFT core. It sits between the register map and the FFT core's config slave port. It captures per-channel direction and scaling schedule, an optional run-time transform size and an optional cyclic-prefix length on `commit`, then delivers them as a single-beat packed transfer. Commits that arrive while a transfer is outstanding are queued one-deep and sent back-to-back, and lost commits are flagged.

## Interface

- `NUM_CHANNELS`, 1, number of FFT channels (1..8)
- `SCALE_WIDTH`, 8, scaling-schedule bits per channel (2..16)
- `HAS_NFFT`, 0, 1 = include run-time NFFT field
- `HAS_CP`, 0, 1 = include cyclic-prefix length field
- `CP_WIDTH`, 12, cyclic-prefix length bits (1..16)
- `TDATA_WIDTH`, derived localparam, not overridable: ceil8(NFFT_F + CP_F + NUM_CHANNELS*(1+SCALE_WIDTH)), where NFFT_F = HAS_NFFT?8:0 and CP_F = HAS_CP?ceil8(CP_WIDTH):0

- `clk` in 1: clock
- `resetn` in 1: synchronous, active-low reset
- `nfft` in 5: log2 transform size; ignored if HAS_NFFT=0
- `cp_len` in CP_WIDTH: cyclic-prefix length; ignored if HAS_CP=0
- `forward` in NUM_CHANNELS: 1 = forward transform, per channel
- `scale_sch` in NUM_CHANNELS*SCALE_WIDTH: channel k in bits [k*SCALE_WIDTH +: SCALE_WIDTH]
- `commit` in 1: single-cycle request to send the current inputs
- `clear_overrun` in 1: clears `overrun`
- `tready` in 1: AXIS ready from FFT core
- `tvalid` out 1: AXIS valid
- `tlast` out 1: AXIS last
- `tdata` out TDATA_WIDTH: packed config word
- `busy` out 1: transfer outstanding (equals `tvalid`)
- `pending` out 1: one queued config waiting
- `overrun` out 1: sticky, a queued config was overwritten
- `sent_count` out 16: completed handshakes, wraps at 65535 -> 0

## Operation

- Packing, LSB first:
  - nfft zero-extended to 8 bits (if HAS_NFFT)
  - cp_len zero-extended to CP_F bits (if HAS_CP)
  - forward[NUM_CHANNELS-1:0]
  - scale_sch
  - zero pad to TDATA_WIDTH
- With defaults: tdata = {7'b0, scale_sch[7:0], forward[0]}.
- Registers:
  - shadow word: drives `tdata`
  - queue word plus `pending` flag
- State IDLE:
  - `commit` -> pack inputs into shadow, go to SEND.
- State SEND:
  - `tvalid`=1; `tdata` held stable until handshake (tvalid & tready).
  - `commit` without handshake -> pack into queue, set `pending`. If `pending` was already 1, the queue is overwritten (latest wins) and `overrun` is set.
  - Handshake without `commit`:
    - `pending`=1 -> queue moves to shadow, clear `pending`, stay in SEND.
    - `pending`=0 -> go to IDLE.
  - Handshake with `commit` in the same cycle -> the commit inputs go to shadow, stay in SEND. If `pending`=1, the queued word is discarded, `pending` clears and `overrun` is set.
- `sent_count` increments by 1 on every handshake.
- `clear_overrun` clears `overrun`. If it coincides with a new overrun event, the set wins.
- `tlast` = `tvalid` at all times, since every transfer is one beat.
- Inputs other than `commit` are sampled only on the `commit` cycle.

## Timing

- Synchronous reset (`resetn`=0 at a clk edge) overrides everything. After reset:
  - state IDLE
  - `tvalid`=`tlast`=`busy`=`pending`=`overrun`=0
  - `tdata`=0, `sent_count`=0, queue cleared
- Reset mid-transfer drops the outstanding and queued words. `tvalid` falls on that edge with no handshake counted.
- Latency: `commit` sampled at edge N -> `tvalid`=1 with the packed word after edge N, so first acceptance is possible at edge N+1.
- `tready` already high: one transfer per 2 cycles from IDLE. Back-to-back via queue: one transfer per cycle, `tvalid` continuously high.
- `tvalid` never drops without a handshake, except on reset. `tdata` never changes while `tvalid`=1 and `tready`=0.
- All outputs are registered; there is no combinational path from `tready` or `commit` to any output.

## Test plan

- **Defaults, single commit:** forward=1, scale_sch=8'hAA, commit, tready=1 -> tvalid/tlast=1 for exactly one cycle, starting the cycle after commit; tdata=16'h0155; sent_count=1.
- **Backpressure:** tready=0 for 10 cycles after commit, then 1 -> tdata stable for all 11 valid cycles; one handshake; busy falls the following cycle.
- **Queue and overrun:** while stalled, commit A then commit B (scale 8'h11, 8'h22) -> pending=1, overrun=1. On release, the first transfer is the original word, followed immediately by B (tdata=16'h0044 with forward=0). A is never sent. sent_count=2.
- **Handshake-coincident commit:** commit on the handshake cycle with pending=0 -> next beat follows with no tvalid gap; pending stays 0; overrun stays 0.
- **Full layout:** NUM_CHANNELS=2, SCALE_WIDTH=6, HAS_NFFT=1, HAS_CP=1, CP_WIDTH=10; nfft=5'd10, cp_len=10'h3FF, forward=2'b10, scale_sch=12'hABC -> TDATA_WIDTH=40; tdata=40'h2AF20_3FF0A (bits 37:26=ABC, 25:24=10, 23:8=03FF, 7:0=0A).
- **Reset mid-transfer:** stalled tvalid plus pending, pulse resetn=0 -> all outputs 0 on the next edge; a new commit afterwards sends only the new word.
